round_key_sequencer: RTL and testbench
======================================

# round_key_sequencer

Control and storage stage directly downstream of the AES-256 key-schedule block. It drives that block's round index and enable, and captures each 128-bit round key one cycle after the done pulse. It holds all 15 round keys in a local register file and serves them by index to the cipher round datapath through a registered read port. It flags completion, and flags a stalled key-schedule handshake through a watchdog.

## Interface
Parameters:
- NUM_ROUNDS, 14, last round-key index; the store holds NUM_ROUNDS+1 keys.
- KEY_W, 128, round-key width.
- TIMEOUT, 64, max cycles in RUN without ks_done_i before ERROR (≥4).

Ports:
- clk_g  in  1  clock, gated upstream.
- rst_n  in  1  reset: asynchronous, active-low.
- start_i  in  1  one-cycle pulse, begin expansion; honoured in IDLE, READY, ERROR only.
- ks_en_o  out  1  enable to key schedule.
- ks_round_o  out  4  round index to key schedule.
- ks_done_i  in  1  key-schedule done pulse.
- ks_key_i  in  KEY_W  key-schedule output key; valid the cycle after ks_done_i.
- rd_en_i  in  1  read request.
- rd_idx_i  in  4  round-key index to read.
- rd_key_o  out  KEY_W  read data.
- busy_o  out  1  high in RUN and CAPTURE.
- valid_o  out  1  all keys stored and current.
- err_o  out  1  watchdog fired.

## Operation
- States: IDLE, RUN, CAPTURE, READY, ERROR. Reset state is IDLE.
- IDLE/READY/ERROR + start_i:
  - round counter ← 0, watchdog ← 0, valid_o ← 0, err_o ← 0.
  - go to RUN.
- RUN:
  - ks_en_o=1; ks_round_o = round counter.
  - Watchdog increments every cycle.
  - On ks_done_i, go to CAPTURE.
  - If the watchdog reaches TIMEOUT-1 without ks_done_i, go to ERROR.
- CAPTURE (1 cycle):
  - ks_en_o=0; ks_round_o held.
  - slot[counter] ← ks_key_i; watchdog ← 0.
  - If counter==NUM_ROUNDS, go to READY and set valid_o=1.
  - Otherwise increment counter and return to RUN.
- READY: ks_en_o=0; hold until start_i.
- ERROR: err_o=1; ks_en_o=0; hold until start_i.
- start_i in RUN or CAPTURE is ignored.
- ks_done_i outside RUN is ignored.
- Reads are serviced in every state.
  - rd_idx_i > NUM_ROUNDS returns all-zero.
  - Reads before valid_o return the slot's current content. This is a defined value, not a guaranteed key.
- Restart does not clear the slots; they are overwritten in order.
- Round counter is 4 bits and never wraps: NUM_ROUNDS ≤ 15.

## Timing
- Reset values:
  - ks_en_o=0, ks_round_o=0, rd_key_o=0, busy_o=0, valid_o=0, err_o=0.
  - All slots = 0; all counters = 0.
- Reset mid-operation returns to IDLE immediately (asynchronous). The next start_i begins from round 0.
- start_i sampled at edge k: RUN from k+1, so ks_en_o is high in cycle k+1.
- ks_done_i high at edge j: CAPTURE in cycle j+1, and ks_key_i is sampled at edge j+1.
  - valid_o rises in cycle j+2 for the last round.
- ks_round_o is stable from RUN entry through the end of CAPTURE. The key schedule sees a steady index across its done and key-update edges.
- Per-key cost: key-schedule latency + 1 CAPTURE cycle.
- Read latency is 1 cycle: rd_en_i at edge r updates rd_key_o at edge r. rd_key_o holds when rd_en_i=0.
- Simultaneous CAPTURE write and read of the same slot returns the old value (read-before-write).

## Structure
- Shared package aes_pkg holds:
  - state enum rks_state_e {IDLE, RUN, CAPTURE, READY, ERROR}.
  - AES256_NUM_ROUNDS=14 and AES_KEY_W=128.
- One sub-module, round_key_regfile:
  - (NUM_ROUNDS+1)×KEY_W storage.
  - Single write port, synchronous registered read port with rd_en.
  - Zero-on-reset; out-of-range index reads zero.
- The FSM, round counter and watchdog stay in round_key_sequencer.

## Test plan
- Full expansion with the real key schedule and key 000102…1e1f, then read indices 0, 1, 2, 14:
  - slot 0 = 000102030405060708090a0b0c0d0e0f.
  - slot 1 = 101112131415161718191a1b1c1d1e1f.
  - slot 2 = a573c29fa176c498a97fce93a572c09c.
  - slot 14 = 24fc79ccbf0979e9371ac23c6d68de36.
  - valid_o=1, err_o=0, busy_o=0.
- Stub key schedule with done after 3 cycles, keys 0x…00..0x…0e:
  - 15 CAPTURE cycles occur.
  - ks_round_o steps 0→14, each value constant across its done and capture edges.
  - valid_o rises exactly 2 cycles after the 15th done.
- Stub never asserts done, TIMEOUT=8:
  - err_o=1 after 8 RUN cycles; ks_en_o=0.
  - A following start_i clears err_o and round 0 restarts.
- rst_n low during round 7:
  - All outputs reach their reset values asynchronously; round_key_regfile slots clear to 0.
  - A new start re-expands from round 0 and valid_o is set only after round 14.
- Reads:
  - rd_idx_i=15 returns 0.
  - A read of slot 5 in the same cycle as its CAPTURE returns the old value, then the new value on the next read.
  - start_i pulses during RUN change no state.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions for the round-key store.
//   rks_state_e        : sequencer state encoding
//   AES256_NUM_ROUNDS  : last round-key index for AES-256
//   AES_KEY_W          : round-key width
//   RND_W              : width of round index / read index buses
package aes_pkg;

  localparam int AES256_NUM_ROUNDS = 14;
  localparam int AES_KEY_W         = 128;
  localparam int RND_W             = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    CAPTURE = 3'd2,
    READY   = 3'd3,
    ERROR   = 3'd4
  } rks_state_e;

endpackage

// File: rtl/round_key_sequencer_if.sv
// Signal bundle between the round-key sequencer and its neighbours
// (key-schedule block, cipher round datapath, control).
//   slave  : the sequencer side
//   master : the side driving start, key-schedule results and reads
// Signals: start_i, ks_en_o, ks_round_o, ks_done_i, ks_key_i,
//          rd_en_i, rd_idx_i, rd_key_o, busy_o, valid_o, err_o
interface round_key_sequencer_if #(
  parameter int KEY_W = aes_pkg::AES_KEY_W
);

  logic                      start_i;
  logic                      ks_en_o;
  logic [aes_pkg::RND_W-1:0] ks_round_o;
  logic                      ks_done_i;
  logic [KEY_W-1:0]          ks_key_i;
  logic                      rd_en_i;
  logic [aes_pkg::RND_W-1:0] rd_idx_i;
  logic [KEY_W-1:0]          rd_key_o;
  logic                      busy_o;
  logic                      valid_o;
  logic                      err_o;

  modport slave (
    input  start_i, ks_done_i, ks_key_i, rd_en_i, rd_idx_i,
    output ks_en_o, ks_round_o, rd_key_o, busy_o, valid_o, err_o
  );

  modport master (
    output start_i, ks_done_i, ks_key_i, rd_en_i, rd_idx_i,
    input  ks_en_o, ks_round_o, rd_key_o, busy_o, valid_o, err_o
  );

endinterface

// File: rtl/round_key_sequencer_regfile.sv
// round_key_regfile: (NUM_ROUNDS+1) x KEY_W round-key store.
// One synchronous write port, one registered read port.
//   clk_g, rst_n : clock, async active-low reset (clears all slots)
//   wr_en, wr_idx, wr_key : write port
//   rd_en, rd_idx, rd_key : read port, rd_key updates only when rd_en
// Out-of-range read indices return zero. A read and write of the same
// slot on one edge returns the old content.
module round_key_regfile
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES256_NUM_ROUNDS,
  parameter int KEY_W      = AES_KEY_W
) (
  input  logic             clk_g,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [RND_W-1:0] wr_idx,
  input  logic [KEY_W-1:0] wr_key,
  input  logic             rd_en,
  input  logic [RND_W-1:0] rd_idx,
  output logic [KEY_W-1:0] rd_key
);

  localparam logic [RND_W-1:0] LAST_IDX = RND_W'(NUM_ROUNDS);

  logic [KEY_W-1:0] slot [0:NUM_ROUNDS];

  always_ff @(posedge clk_g or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        slot[i] <= '0;
      end
    end else if (wr_en && (wr_idx <= LAST_IDX)) begin
      slot[wr_idx] <= wr_key;
    end
  end

  // Reads see the pre-edge slot content, giving read-before-write.
  always_ff @(posedge clk_g or negedge rst_n) begin
    if (!rst_n) begin
      rd_key <= '0;
    end else if (rd_en) begin
      rd_key <= (rd_idx <= LAST_IDX) ? slot[rd_idx] : '0;
    end
  end

endmodule

// File: rtl/round_key_sequencer.sv
// round_key_sequencer: drives the AES-256 key schedule round by round,
// captures each round key into round_key_regfile, serves indexed reads,
// and flags completion or a stalled key-schedule handshake.
//   clk_g, rst_n : clock, async active-low reset
//   bus          : round_key_sequencer_if.slave (start, key-schedule
//                  handshake, read port, status flags)
//
// state   | meaning
// --------+-------------------------------------------------------
// IDLE    | after reset, waiting for start
// RUN     | key schedule enabled for current round, watchdog counting
// CAPTURE | store ks_key_i into slot[round], advance or finish
// READY   | all keys stored, valid_o high
// ERROR   | watchdog expired in RUN, err_o high
module round_key_sequencer
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES256_NUM_ROUNDS,
  parameter int KEY_W      = AES_KEY_W,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk_g,
  input  logic                  rst_n,
  round_key_sequencer_if.slave  bus
);

  localparam int               WD_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS);

  rks_state_e       state_q, state_d;
  logic [RND_W-1:0] round_q, round_d;
  logic [WD_W-1:0]  wd_q, wd_d;

  logic ks_en;
  logic busy;
  logic valid;
  logic err;
  logic wr_en;

  always_ff @(posedge clk_g or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      round_q <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    wd_d    = wd_q;
    ks_en   = 1'b0;
    busy    = 1'b0;
    valid   = 1'b0;
    err     = 1'b0;
    wr_en   = 1'b0;

    case (state_q)
      IDLE, READY, ERROR: begin
        valid = (state_q == READY);
        err   = (state_q == ERROR);
        if (bus.start_i) begin
          round_d = '0;
          wd_d    = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        ks_en = 1'b1;
        busy  = 1'b1;
        wd_d  = wd_q + WD_W'(1);
        // A done on the final watchdog cycle still wins.
        if (bus.ks_done_i) begin
          state_d = CAPTURE;
        end else if (wd_q == WD_LAST) begin
          state_d = ERROR;
        end
      end

      CAPTURE: begin
        busy  = 1'b1;
        wr_en = 1'b1;
        wd_d  = '0;
        if (round_q == LAST_RND) begin
          state_d = READY;
        end else begin
          round_d = round_q + RND_W'(1);
          state_d = RUN;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  round_key_regfile #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .KEY_W      (KEY_W)
  ) u_regfile (
    .clk_g  (clk_g),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .wr_idx (round_q),
    .wr_key (bus.ks_key_i),
    .rd_en  (bus.rd_en_i),
    .rd_idx (bus.rd_idx_i),
    .rd_key (bus.rd_key_o)
  );

  // ks_round_o comes straight from the counter, which only moves at the
  // end of CAPTURE, so it is steady across the done and key edges.
  assign bus.ks_en_o    = ks_en;
  assign bus.ks_round_o = round_q;
  assign bus.busy_o     = busy;
  assign bus.valid_o    = valid;
  assign bus.err_o      = err;

endmodule

// File: tb/tb_round_key_sequencer.sv
// Directed bench for round_key_sequencer with a behavioural key-schedule
// stub (real AES-256 expansion, counter keys, or never-done).
module tb_round_key_sequencer;

  logic clk_g = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_g = ~clk_g;

  round_key_sequencer_if #(.KEY_W(128)) rif ();

  round_key_sequencer #(
    .NUM_ROUNDS (14),
    .KEY_W      (128),
    .TIMEOUT    (8)
  ) dut (
    .clk_g (clk_g),
    .rst_n (rst_n),
    .bus   (rif)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- AES-256 reference key expansion ----------------
  logic [7:0]   sbox [256];
  logic [127:0] rk_real [16];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic build_model();
    logic [31:0]  w [60];
    logic [255:0] key;
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (i % 8 == 4) begin
        t = subword(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) rk_real[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    rk_real[15] = '0;
  endtask

  // ---------------- key-schedule stub ----------------
  // mode 0: real keys, mode 1: key = round index, mode 2: never done
  int ks_mode = 0;
  int stub_lat = 3;
  int stub_cnt = 0;

  initial begin
    rif.ks_done_i = 1'b0;
    rif.ks_key_i  = '0;
    forever begin
      @(posedge clk_g);
      #1;
      if (rif.ks_en_o) begin
        stub_cnt++;
        rif.ks_done_i = (ks_mode != 2) && (stub_cnt == stub_lat);
      end else begin
        stub_cnt      = 0;
        rif.ks_done_i = 1'b0;
        rif.ks_key_i  = (ks_mode == 0) ? rk_real[rif.ks_round_o] : {124'h0, rif.ks_round_o};
      end
    end
  end

  // ---------------- handshake monitor ----------------
  int   cyc = 0;
  int   last_done_cyc = 0;
  int   cap_cnt = 0;
  int   exp_round = 0;
  logic [3:0] done_round = '0;
  logic prev_valid = 1'b0;

  initial begin
    forever begin
      @(negedge clk_g);
      cyc++;
      if (rst_n) begin
        if (rif.ks_done_i && rif.ks_en_o) begin
          done_round    = rif.ks_round_o;
          last_done_cyc = cyc;
        end
        if (rif.busy_o && !rif.ks_en_o) begin
          cap_cnt++;
          chk("cap_round", rif.ks_round_o, exp_round);
          chk("round_hold", rif.ks_round_o, done_round);
          exp_round++;
        end
        if (rif.valid_o && !prev_valid) begin
          chk("valid_lat", cyc - last_done_cyc, 2);
          chk("valid_after_14", cap_cnt, 15);
        end
      end
      prev_valid = rif.valid_o;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start();
    cap_cnt     = 0;
    exp_round   = 0;
    rif.start_i = 1'b1;
    @(negedge clk_g);
    rif.start_i = 1'b0;
  endtask

  task automatic rd(input logic [3:0] idx, input logic [127:0] exp, input string tag);
    rif.rd_en_i  = 1'b1;
    rif.rd_idx_i = idx;
    @(negedge clk_g);
    rif.rd_en_i  = 1'b0;
    chk(tag, rif.rd_key_o, exp);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!rif.valid_o && n < 300) begin
      @(negedge clk_g);
      n++;
    end
    chk(tag, rif.valid_o, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    int en_cyc;
    rif.start_i  = 1'b0;
    rif.rd_en_i  = 1'b0;
    rif.rd_idx_i = '0;
    build_model();

    // reset values
    repeat (3) @(negedge clk_g);
    chk("rst_ks_en", rif.ks_en_o, 1'b0);
    chk("rst_round", rif.ks_round_o, 4'd0);
    chk("rst_rd_key", rif.rd_key_o, 128'h0);
    chk("rst_busy", rif.busy_o, 1'b0);
    chk("rst_valid", rif.valid_o, 1'b0);
    chk("rst_err", rif.err_o, 1'b0);
    rst_n = 1'b1;
    @(negedge clk_g);

    // full expansion with real keys
    ks_mode = 0;
    pulse_start();
    chk("run_ks_en", rif.ks_en_o, 1'b1);
    wait_valid("real_done");
    chk("real_caps", cap_cnt, 15);
    chk("real_err", rif.err_o, 1'b0);
    chk("real_busy", rif.busy_o, 1'b0);
    rd(4'd0,  128'h000102030405060708090a0b0c0d0e0f, "real_slot0");
    rd(4'd1,  128'h101112131415161718191a1b1c1d1e1f, "real_slot1");
    rd(4'd2,  128'ha573c29fa176c498a97fce93a572c09c, "real_slot2");
    rd(4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36, "real_slot14");

    // counter keys, start during RUN, read-before-write on slot 5
    ks_mode = 1;
    pulse_start();
    chk("restart_valid_clr", rif.valid_o, 1'b0);
    n = 0;
    while (!(rif.ks_en_o && rif.ks_round_o == 4'd3) && n < 100) begin
      @(negedge clk_g);
      n++;
    end
    chk("reach_round3", rif.ks_round_o, 4'd3);
    rif.start_i = 1'b1;
    @(negedge clk_g);
    rif.start_i = 1'b0;
    chk("start_in_run_en", rif.ks_en_o, 1'b1);
    chk("start_in_run_round", rif.ks_round_o, 4'd3);
    n = 0;
    while (!(rif.busy_o && !rif.ks_en_o && rif.ks_round_o == 4'd5) && n < 100) begin
      @(negedge clk_g);
      n++;
    end
    chk("reach_cap5", rif.ks_round_o, 4'd5);
    rif.rd_en_i  = 1'b1;
    rif.rd_idx_i = 4'd5;
    @(negedge clk_g);
    chk("rbw_old", rif.rd_key_o, rk_real[5]);
    @(negedge clk_g);
    rif.rd_en_i = 1'b0;
    chk("rbw_new", rif.rd_key_o, 128'd5);
    @(negedge clk_g);
    chk("rd_hold", rif.rd_key_o, 128'd5);
    wait_valid("cnt_done");
    rd(4'd15, 128'h0, "rd_idx15");
    rd(4'd9,  128'd9, "cnt_slot9");

    // watchdog with never-done stub
    ks_mode = 2;
    pulse_start();
    en_cyc = 0;
    n = 0;
    while (!rif.err_o && n < 40) begin
      if (rif.ks_en_o) en_cyc++;
      @(negedge clk_g);
      n++;
    end
    chk("wd_err", rif.err_o, 1'b1);
    chk("wd_run_cycles", en_cyc, 8);
    chk("wd_ks_en", rif.ks_en_o, 1'b0);
    chk("wd_valid", rif.valid_o, 1'b0);
    chk("wd_rd_hold", rif.rd_key_o, 128'd9);
    ks_mode = 1;
    pulse_start();
    chk("err_clr", rif.err_o, 1'b0);
    chk("err_restart_en", rif.ks_en_o, 1'b1);
    chk("err_restart_round", rif.ks_round_o, 4'd0);

    // async reset during round 7
    n = 0;
    while (!(rif.ks_en_o && rif.ks_round_o == 4'd7) && n < 100) begin
      @(negedge clk_g);
      n++;
    end
    chk("reach_round7", rif.ks_round_o, 4'd7);
    rst_n = 1'b0;
    #1;
    chk("arst_ks_en", rif.ks_en_o, 1'b0);
    chk("arst_round", rif.ks_round_o, 4'd0);
    chk("arst_rd_key", rif.rd_key_o, 128'h0);
    chk("arst_busy", rif.busy_o, 1'b0);
    chk("arst_valid", rif.valid_o, 1'b0);
    chk("arst_err", rif.err_o, 1'b0);
    repeat (2) @(negedge clk_g);
    rst_n = 1'b1;
    @(negedge clk_g);
    rd(4'd5,  128'h0, "arst_slot5");
    rd(4'd14, 128'h0, "arst_slot14");
    pulse_start();
    chk("re_round0", rif.ks_round_o, 4'd0);
    wait_valid("re_done");
    chk("re_caps", cap_cnt, 15);
    rd(4'd14, 128'd14, "re_slot14");
    rd(4'd7,  128'd7,  "re_slot7");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
